// File: rtl/mem_copy_engine.sv
// Word-granular memory copy/fill engine driving a single-port combinational-read memory.
// Optional fill mode is compiled in with `define MEM_COPY_FILL_EN.

package instruction_set;
    parameter int unsigned   WORD_SIZE = 8;
    parameter logic [1:0]    MEM_NONE  = 2'b00;
    parameter logic [1:0]    MEM_READ  = 2'b01;
    parameter logic [1:0]    MEM_WRITE = 2'b10;
endpackage

module mem_copy_engine
    import instruction_set::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] src,
    input  logic [WORD_SIZE-1:0] dst,
    input  logic [WORD_SIZE-1:0] len,
    input  logic                 fill,
    input  logic [WORD_SIZE-1:0] fill_value,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           mem_op,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] src_q, src_d;
    logic [WORD_SIZE-1:0] dst_q, dst_d;
    logic [WORD_SIZE-1:0] len_q, len_d;
    logic [WORD_SIZE-1:0] i_q, i_d;
    logic [WORD_SIZE-1:0] hold_q, hold_d;

    // fill_start picks the first state on accept; fill_mode steers the running transfer.
    logic                 fill_start;
    logic                 fill_mode;
    logic [WORD_SIZE-1:0] fill_word;

`ifdef MEM_COPY_FILL_EN
    logic                 fill_q, fill_d;
    logic [WORD_SIZE-1:0] fill_value_q, fill_value_d;

    assign fill_start = fill;
    assign fill_mode  = fill_q;
    assign fill_word  = fill_value_q;

    always_comb begin
        fill_d       = fill_q;
        fill_value_d = fill_value_q;
        if (state_q == StIdle && start) begin
            fill_d       = fill;
            fill_value_d = fill_value;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_q       <= 1'b0;
            fill_value_q <= '0;
        end else begin
            fill_q       <= fill_d;
            fill_value_q <= fill_value_d;
        end
    end
`else
    logic unused_fill;

    assign fill_start  = 1'b0;
    assign fill_mode   = 1'b0;
    assign fill_word   = '0;
    assign unused_fill = ^{fill, fill_value, fill_word};
`endif

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        i_d       = i_q;
        hold_d    = hold_q;
        busy      = (state_q != StIdle);
        done      = 1'b0;
        mem_op    = MEM_NONE;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    src_d = src;
                    dst_d = dst;
                    len_d = len;
                    i_d   = '0;
                    if (len == '0) begin
                        state_d = StDone;
                    end else if (fill_start) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                mem_op   = MEM_READ;
                mem_addr = src_q + i_q;
                hold_d   = mem_rdata;
                state_d  = StWrite;
            end
            StWrite: begin
                mem_op    = MEM_WRITE;
                mem_addr  = dst_q + i_q;
                mem_wdata = fill_mode ? fill_word : hold_q;
                i_d       = i_q + 1'b1;
                if (i_d == len_q) begin
                    state_d = StDone;
                end else if (fill_mode) begin
                    state_d = StWrite;
                end else begin
                    state_d = StRead;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            i_q     <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            i_q     <= i_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine: behavioural memory, shadow-memory model and
// write/read scoreboards; fill expectations follow MEM_COPY_FILL_EN.

module tb_mem_copy_engine;
    import instruction_set::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] src, dst, len, fill_value;
    logic       fill;
    logic       busy, done;
    logic [1:0] mem_op;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic       pl_we;
    logic [7:0] pl_addr, pl_data;

    logic [15:0] wr_q [$];
    logic [7:0]  rd_q [$];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_copy_engine dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .fill       (fill),
        .fill_value (fill_value),
        .busy       (busy),
        .done       (done),
        .mem_op     (mem_op),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (mem_op == MEM_WRITE) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every memory write and copy read must match the model's queue head.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (mem_op == MEM_WRITE) begin
                chk("write_expected", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) chk("write_addr_data", {mem_addr, mem_wdata}, wr_q.pop_front());
            end
            if (mem_op == MEM_READ && rd_q.size() != 0) chk("read_addr", mem_addr, rd_q.pop_front());
        end
    end

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic model(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                         input logic f, input logic [7:0] fv, output int lat);
        logic       eff;
        logic [7:0] a, b, v;
`ifdef MEM_COPY_FILL_EN
        eff = f;
`else
        eff = f & 1'b0;
`endif
        for (int i = 0; i < int'(n); i++) begin
            a = s + 8'(i);
            b = d + 8'(i);
            if (!eff) rd_q.push_back(a);
            v = eff ? fv : ref_mem[a];
            ref_mem[b] = v;
            wr_q.push_back({b, v});
        end
        lat = (n == 0) ? 1 : (eff ? int'(n) + 1 : 2 * int'(n) + 1);
    endtask

    task automatic run(input string tag, input logic [7:0] s, input logic [7:0] d,
                       input logic [7:0] n, input logic f, input logic [7:0] fv, input bit inject);
        int exp_lat, lat, extra;
        bit seen;
        model(s, d, n, f, fv, exp_lat);
        start = 1'b1; src = s; dst = d; len = n; fill = f; fill_value = fv;
        lat = 0; seen = 0;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(negedge clk); #1;
            start = 1'b0;
            lat++;
            if (lat == 1) chk({tag, "_busy"}, busy, 1'b1);
            if (inject && lat == 3) begin
                start = 1'b1; src = 8'h30; dst = 8'h70; len = 8'd2; fill = 1'b0;
            end
            if (done === 1'b1) seen = 1;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, lat, exp_lat);
        @(negedge clk); #1;
        chk({tag, "_idle_busy"}, busy, 1'b0);
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            if (done !== 1'b0) extra++;
            @(negedge clk); #1;
        end
        chk({tag, "_extra_done"}, extra, 0);
        chk({tag, "_wr_left"}, wr_q.size(), 0);
        chk({tag, "_rd_left"}, rd_q.size(), 0);
    endtask

    initial begin
        int dn;
        reset = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
        fill = 1'b0; fill_value = '0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_mem_op", mem_op, MEM_NONE);
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_mem_wdata", mem_wdata, 8'h00);

        @(negedge clk);
        for (int a = 0; a < 256; a++) preload(8'(a), 8'h00);
        #1 reset = 1'b1;
        @(negedge clk); #1;

        preload(8'h10, 8'hAA); preload(8'h11, 8'hBB); preload(8'h12, 8'hCC); preload(8'h13, 8'hDD);
        #1 run("copy4", 8'h10, 8'h40, 8'd4, 1'b0, 8'h00, 0);
        chk("copy4_mem43", mem[8'h43], 8'hDD);

        preload(8'h60, 8'h01); preload(8'h61, 8'h02); preload(8'h62, 8'h03);
        #1 run("fill3", 8'h60, 8'h20, 8'd3, 1'b1, 8'h5A, 0);
        chk("fill3_mem21", mem[8'h21], ref_mem[8'h21]);

        run("len0", 8'h10, 8'h90, 8'd0, 1'b0, 8'h00, 0);
        chk("len0_mem90", mem[8'h90], 8'h00);

        preload(8'hFE, 8'hE1); preload(8'hFF, 8'hE2); preload(8'h00, 8'hE3);
        #1 run("wrap", 8'hFE, 8'h80, 8'd3, 1'b0, 8'h00, 0);

        run("overlap", 8'h10, 8'h11, 8'd4, 1'b0, 8'h00, 0);
        chk("overlap_mem14", mem[8'h14], 8'hAA);

        run("busy_start", 8'h10, 8'h50, 8'd4, 1'b0, 8'h00, 1);
        chk("busy_start_mem70", mem[8'h70], 8'h00);

        // Abort a len=8 copy once three writes have landed and the fourth read is on the bus.
        for (int a = 0; a < 8; a++) preload(8'hA0 + 8'(a), 8'h11);
        for (int i = 0; i < 4; i++) rd_q.push_back(8'h40 + 8'(i));
        for (int i = 0; i < 3; i++) begin
            ref_mem[8'hA0 + 8'(i)] = ref_mem[8'h40 + 8'(i)];
            wr_q.push_back({8'hA0 + 8'(i), ref_mem[8'h40 + 8'(i)]});
        end
        #1 start = 1'b1; src = 8'h40; dst = 8'hA0; len = 8'd8; fill = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk); #1;
            start = 1'b0;
        end
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_mem_op", mem_op, MEM_NONE);
        chk("abort_mem_addr", mem_addr, 8'h00);
        dn = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            if (done !== 1'b0) dn++;
        end
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (done !== 1'b0) dn++;
        end
        chk("abort_no_done", dn, 0);
        chk("abort_wr_left", wr_q.size(), 0);
        chk("abort_rd_left", rd_q.size(), 0);
        for (int a = 0; a < 8; a++) chk("abort_mem", mem[8'hA0 + 8'(a)], ref_mem[8'hA0 + 8'(a)]);

        run("post_abort", 8'h11, 8'hC0, 8'd2, 1'b0, 8'h00, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL import WORD_SIZE and the MEM_NONE/MEM_READ/MEM_WRITE op encodings from instruction_set; no local parameters.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset (one clock; reset is asynchronous and active-low).
REQ-004 SHALL have port start, input, 1, request pulse, sampled only in IDLE.
REQ-005 SHALL have ports src, dst, len, input, WORD_SIZE each; source base, destination base and element count, captured on accepted start.
REQ-006 SHALL have port fill, input, 1, fill-mode select, captured on accepted start.
REQ-007 SHALL have port fill_value, input, WORD_SIZE, fill word, captured on accepted start.
REQ-008 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-009 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-010 SHALL have port mem_op, output, 2, drives the memory op input.
REQ-011 SHALL have port mem_addr, output, WORD_SIZE, drives the memory addr input.
REQ-012 SHALL have port mem_wdata, output, WORD_SIZE, drives the memory write_data input.
REQ-013 SHALL have port mem_rdata, input, WORD_SIZE, combinational read_data from memory.

Function
REQ-014 SHALL implement states IDLE, READ, WRITE, DONE.
REQ-015 IDLE: start=1 SHALL capture src/dst/len/fill/fill_value, clear index i, and go to DONE if len=0, else to WRITE if fill=1, else to READ.
REQ-016 READ: mem_op=MEM_READ, mem_addr=src+i; mem_rdata SHALL be latched into hold register at cycle end; next state WRITE.
REQ-017 WRITE: mem_op=MEM_WRITE, mem_addr=dst+i, mem_wdata=hold (copy) or fill_value (fill); i SHALL increment at cycle end.
REQ-018 After WRITE, if i+1=len the next state SHALL be DONE, else READ (copy) or WRITE (fill).
REQ-019 DONE: done=1 for exactly one cycle, mem_op=MEM_NONE; next state IDLE.
REQ-020 In IDLE and DONE, mem_op SHALL be MEM_NONE and mem_addr/mem_wdata SHALL be 0.
REQ-021 Address arithmetic SHALL be modulo 2^WORD_SIZE (src+i and dst+i wrap silently).
REQ-022 Copy SHALL be strictly ascending; overlapping regions with dst>src SHALL replicate source pattern (defined, not an error).
REQ-023 start asserted while busy SHALL be ignored, no queueing.
REQ-024 Latency: copy of N>0 words = 2N+1 cycles start-to-done; fill of N>0 = N+1; len=0 = 1.
REQ-025 Outputs SHALL be registered-state decodes only; mem_rdata SHALL not reach any output combinationally.

Reset
REQ-026 reset=0 SHALL force IDLE, clear i, hold and all captured registers immediately, regardless of clock.
REQ-027 Reset values: busy=0, done=0, mem_op=MEM_NONE, mem_addr=0, mem_wdata=0.
REQ-028 Reset mid-transfer SHALL abandon it without done; writes already issued remain.

Configuration
REQ-029 Macro MEM_COPY_FILL_EN SHALL gate fill mode.
REQ-030 Defined: behaviour per REQ-015..REQ-018 including fill.
REQ-031 Undefined: fill and fill_value ports remain but are ignored; every transfer is a copy.

Verification
REQ-032 Copy: mem[0x10..0x13]=AA,BB,CC,DD; start src=0x10 dst=0x40 len=4 -> mem[0x40..0x43]=AA,BB,CC,DD, done 9 cycles after start.
REQ-033 Fill (macro on): start dst=0x20 len=3 fill=1 fill_value=0x5A -> mem[0x20..0x22]=5A, done after 4 cycles; macro off -> copy from src instead.
REQ-034 len=0 -> done next cycle, mem_op never MEM_WRITE.
REQ-035 Wrap: src=0xFE dst=0x80 len=3 -> reads 0xFE,0xFF,0x00; writes 0x80..0x82.
REQ-036 Second start during busy -> ignored, one done only; reset=0 mid-copy of len=8 after 3 writes -> busy=0 at once, no done, mem[dst+3..] unchanged.
